cpu_gen2: RTL and testbench
===========================

# cpu_gen2

Parametrised second-generation accumulator CPU for the mother board. Keeps the two-register (A, B) and carry-flag programming model and the 4-bit opcode map of the current CPU. Widens the datapath and program counter through parameters and adds multiple input/output channels. Adds a wait-state instruction-fetch handshake, a subtract instruction and a halt state. Sits between the program ROM (or a slower instruction memory) and the board switches and LEDs.

## Interface
- DATA_W, 4: width of A, B, immediate, I/O channels; ≥ 2
- ADDR_W, 4: program counter / instruction address width; ≥ 1
- N_IN, 1: number of input channels; 1..2^DATA_W
- N_OUT, 1: number of output channels; 1..2^DATA_W

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_addr  out  ADDR_W  instruction address (= pc)
- imem_req  out  1  fetch request; high while in FETCH
- imem_valid  in  1  imem_data valid for imem_addr this cycle
- imem_data  in  4+DATA_W  instruction; [DATA_W+3:DATA_W] opcode, [DATA_W-1:0] imm
- switch  in  N_IN*DATA_W  input channels; channel k at [k*DATA_W +: DATA_W]
- led  out  N_OUT*DATA_W  registered output channels, same packing
- halted  out  1  high while in HALT

## Operation
- State: a, b (DATA_W), cf (1), pc (ADDR_W), out[N_OUT] (DATA_W each), fsm ∈ {FETCH, HALT}.
- FETCH: imem_req=1, imem_addr=pc.
  - imem_valid=0: nothing changes.
  - imem_valid=1: the instruction executes on that edge. Default pc←pc+1 (mod 2^ADDR_W) and cf←0.
- HALT: imem_req=0, no state changes; only reset leaves HALT.
- Opcodes (imm = low DATA_W bits; "idx" = imm used as channel index):
  - 0000 ADD A,imm: {cf,a}←a+imm, DATA_W+1-bit sum.
  - 0101 ADD B,imm: {cf,b}←b+imm.
  - 1000 SUB A,imm: a←a−imm mod 2^DATA_W; cf←1 iff imm>a (borrow).
  - 0011 MOV A,imm: a←imm. 0111 MOV B,imm: b←imm.
  - 0001 MOV A,B: a←b. 0100 MOV B,A: b←a.
  - 0010 IN A: a←switch[idx]. 0110 IN B: b←switch[idx]. idx≥N_IN reads 0.
  - 1001 OUT B: out[idx]←b. 1011 OUT imm: out[0]←imm. An OUT B with idx≥N_OUT writes nothing.
  - 1111 JMP: pc←imm. 1110 JNC: pc←imm if cf=0, else pc+1.
  - Jump targets are imm zero-extended or truncated to ADDR_W.
  - 1100 HLT: fsm←HALT, pc unchanged.
  - Any other opcode: NOP (pc+1, cf←0).
- cf: only ADD/SUB set it. Every other executed instruction clears it, JNC included. JNC tests cf left by the immediately preceding executed instruction. Fetch wait cycles do not affect cf.

## Timing
- Reset is sampled on a rising edge and overrides everything, including imem_valid=1 on the same edge.
  - Result: a=b=cf=pc=0, all led=0, fsm=FETCH, halted=0.
  - The cycle after reset deasserts: imem_req=1, imem_addr=0.
  - Reset during a wait state or during HALT behaves identically.
- Zero-wait memory (imem_valid tied 1) gives one instruction per cycle.
- Each wait cycle adds exactly one cycle. imem_data is ignored when imem_valid=0.
- led and halted are registered outputs. A new value appears the cycle after the executing edge.
- pc wraps from 2^ADDR_W−1 to 0 with no flag.
- Writes to a register read by the same instruction use the old value (MOV A,B with B changing is not possible; single write per instruction).

## Test plan
- Defaults, imem_valid=1: program MOV A,3; ADD A,14; JNC 0; OUT imm 5; HLT -> a=1 with cf=1, JNC falls through, led=5, then halted=1 and imem_req=0.
- DATA_W=8, ADDR_W=6, N_IN=2, N_OUT=3: switch ch1=0xA5; IN B idx1; OUT B idx2; OUT B idx3 -> led ch2=0xA5; ch0 and ch1 stay 0; idx3 write is ignored.
- Wait states: imem_valid low for 3 cycles before each of ADD A,1 ×2 -> a=2 after 8 cycles; pc steps 0→1→2 only on valid edges; cf stays 0.
- SUB borrow: MOV A,2; SUB A,3; JNC 7 -> a=0xF (DATA_W=4), cf=1, no jump; pc=3.
- Wrap and reset: JMP 15 then NOP -> pc=0. Assert reset while halted with led≠0 -> next cycle all outputs at reset values and imem_addr=0.

Source files
------------

// File: rtl/cpu_gen2_if.sv
// Instruction-fetch bus between cpu_gen2 and its program memory.
// The memory may insert wait states by holding imem_valid low.
interface cpu_gen2_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_req;
    logic              imem_valid;
    logic [DATA_W+3:0] imem_data;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_valid,
        input  imem_data
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_valid,
        output imem_data
    );
endinterface

// File: rtl/cpu_gen2.sv
// Parametrised accumulator CPU: A/B registers, carry flag, 4-bit opcodes,
// multi-channel switch inputs and registered LED outputs, wait-state fetch.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_FETCH | imem_req high; instruction executes on any edge with valid
// S_HALT  | imem_req low, all state frozen; only reset leaves
module cpu_gen2 #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4,
    parameter int N_IN   = 1,
    parameter int N_OUT  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    cpu_gen2_if.master              imem,
    input  logic [N_IN*DATA_W-1:0]  switch,
    output logic [N_OUT*DATA_W-1:0] led,
    output logic                    halted
);
    typedef enum logic {
        S_FETCH = 1'b0,
        S_HALT  = 1'b1
    } state_t;

    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_AI = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_BI = 4'b0111;
    localparam logic [3:0] OP_SUB_A  = 4'b1000;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_OUT_I  = 4'b1011;
    localparam logic [3:0] OP_HLT    = 4'b1100;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              cf_q, cf_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] out_q [N_OUT];
    logic [DATA_W-1:0] out_d [N_OUT];

    logic [3:0]        opcode;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] in_sel;
    logic [ADDR_W-1:0] jmp_tgt;

    assign opcode  = imem.imem_data[DATA_W+3:DATA_W];
    assign imm     = imem.imem_data[DATA_W-1:0];
    // Jump target is the immediate zero-extended or truncated to the pc width.
    assign jmp_tgt = ADDR_W'(imm);

    assign imem.imem_addr = pc_q;
    assign imem.imem_req  = (state_q == S_FETCH);
    assign halted         = (state_q == S_HALT);

    genvar g;
    generate
        for (g = 0; g < N_OUT; g++) begin : g_led
            assign led[g*DATA_W +: DATA_W] = out_q[g];
        end
    endgenerate

    // Input channel mux; indices beyond the last channel read as zero.
    always_comb begin
        in_sel = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (imm == DATA_W'(k)) begin
                in_sel = switch[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and execute logic; nothing moves unless fetching with valid data.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cf_d    = cf_q;
        pc_d    = pc_q;
        out_d   = out_q;
        if (state_q == S_FETCH && imem.imem_valid) begin
            pc_d = pc_q + ADDR_W'(1);
            cf_d = 1'b0;
            unique case (opcode)
                OP_ADD_A:  {cf_d, a_d} = {1'b0, a_q} + {1'b0, imm};
                OP_ADD_B:  {cf_d, b_d} = {1'b0, b_q} + {1'b0, imm};
                OP_SUB_A: begin
                    a_d  = a_q - imm;
                    cf_d = (imm > a_q);
                end
                OP_MOV_AI: a_d = imm;
                OP_MOV_BI: b_d = imm;
                OP_MOV_AB: a_d = b_q;
                OP_MOV_BA: b_d = a_q;
                OP_IN_A:   a_d = in_sel;
                OP_IN_B:   b_d = in_sel;
                OP_OUT_B: begin
                    for (int k = 0; k < N_OUT; k++) begin
                        if (imm == DATA_W'(k)) begin
                            out_d[k] = b_q;
                        end
                    end
                end
                OP_OUT_I:  out_d[0] = imm;
                OP_JMP:    pc_d = jmp_tgt;
                OP_JNC: begin
                    if (!cf_q) begin
                        pc_d = jmp_tgt;
                    end
                end
                OP_HLT: begin
                    state_d = S_HALT;
                    pc_d    = pc_q;
                end
                default: ;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            a_q     <= '0;
            b_q     <= '0;
            cf_q    <= 1'b0;
            pc_q    <= '0;
            for (int k = 0; k < N_OUT; k++) begin
                out_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cf_q    <= cf_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
        end
    end
endmodule

// File: tb/tb_cpu_gen2.sv
// Bench for cpu_gen2: a behavioural model of the programming model runs
// alongside the main instance (DATA_W=4, ADDR_W=4, N_IN=2, N_OUT=3) and is
// compared every cycle; directed programs pin literal results, and a second
// 8-bit instance covers the wide datapath and jump-target truncation.
module tb_cpu_gen2;
    localparam int DW = 4;
    localparam int AW = 4;
    localparam int NI = 2;
    localparam int NO = 3;

    logic clk;
    logic reset;
    logic [NI*DW-1:0] sw;
    logic [NO*DW-1:0] led;
    logic             halted;
    logic [7:0]       rom [16];
    logic [7:0]       junk;

    logic             reset_w;
    logic [15:0]      sw_w;
    logic [23:0]      led_w;
    logic             halted_w;
    logic [11:0]      rom_w [64];
    logic [11:0]      junk_w;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    cpu_gen2_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    cpu_gen2_if #(.DATA_W(8),  .ADDR_W(6))  bus_w ();

    assign bus.imem_data   = bus.imem_valid ? rom[bus.imem_addr] : junk;
    assign bus_w.imem_data = bus_w.imem_valid ? rom_w[bus_w.imem_addr] : junk_w;

    cpu_gen2 #(.DATA_W(DW), .ADDR_W(AW), .N_IN(NI), .N_OUT(NO)) dut (
        .clk    (clk),
        .reset  (reset),
        .imem   (bus),
        .switch (sw),
        .led    (led),
        .halted (halted)
    );

    cpu_gen2 #(.DATA_W(8), .ADDR_W(6), .N_IN(2), .N_OUT(3)) dut_w (
        .clk    (clk),
        .reset  (reset_w),
        .imem   (bus_w),
        .switch (sw_w),
        .led    (led_w),
        .halted (halted_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: plain integer arithmetic on the programming model.
    int m_a, m_b, m_cf, m_pc, m_halt;
    int m_out [NO];

    always @(posedge clk) begin
        int op, imm, npc, ncf, t;
        if (reset) begin
            m_a = 0; m_b = 0; m_cf = 0; m_pc = 0; m_halt = 0;
            for (int k = 0; k < NO; k++) m_out[k] = 0;
        end else if (m_halt == 0 && bus.imem_valid === 1'b1) begin
            op  = int'(rom[m_pc]) / 16;
            imm = int'(rom[m_pc]) % 16;
            npc = (m_pc + 1) % 16;
            ncf = 0;
            case (op)
                0:  begin t = m_a + imm; m_a = t % 16; ncf = t / 16; end
                5:  begin t = m_b + imm; m_b = t % 16; ncf = t / 16; end
                8:  begin ncf = (imm > m_a) ? 1 : 0; m_a = (m_a - imm + 16) % 16; end
                3:  m_a = imm;
                7:  m_b = imm;
                1:  m_a = m_b;
                4:  m_b = m_a;
                2:  m_a = (imm < NI) ? int'(sw >> (imm * DW)) % 16 : 0;
                6:  m_b = (imm < NI) ? int'(sw >> (imm * DW)) % 16 : 0;
                9:  if (imm < NO) m_out[imm] = m_b;
                11: m_out[0] = imm;
                15: npc = imm % 16;
                14: if (m_cf == 0) npc = imm % 16;
                12: begin m_halt = 1; npc = m_pc; end
                default: ;
            endcase
            m_pc = npc;
            m_cf = ncf;
        end
    end

    // Single compare process: outputs against the model on every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
            check("imem_req", 32'(bus.imem_req), 32'(m_halt == 0));
            check("halted", 32'(halted), 32'(m_halt));
            for (int k = 0; k < NO; k++) begin
                check($sformatf("led%0d", k), 32'(led[k*DW +: DW]), 32'(m_out[k]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        junk   = 8'($urandom);
        junk_w = 12'($urandom);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'hA0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.imem_valid = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        reset_w = 1'b1;
        bus.imem_valid = 1'b1;
        bus_w.imem_valid = 1'b1;
        sw = '0;
        sw_w = 16'hA500;
        junk = '0;
        junk_w = '0;
        clear_rom();
        for (int i = 0; i < 64; i++) rom_w[i] = 12'hA00;
        rom_w[0] = 12'hF45;
        rom_w[5] = 12'h601;
        rom_w[6] = 12'h902;
        rom_w[7] = 12'h903;
        rom_w[8] = 12'hC00;

        // Wide instance: JMP 0x45 truncates to 5, then IN/OUT channel routing.
        step();
        chk_en = 1'b1;
        reset_w = 1'b0;
        check("w_reset_addr", 32'(bus_w.imem_addr), 32'h0);
        step();
        check("w_jmp_trunc", 32'(bus_w.imem_addr), 32'h5);
        repeat (4) step();
        check("w_led", 32'(led_w), 32'hA50000);
        check("w_halted", 32'(halted_w), 32'h1);
        check("w_addr", 32'(bus_w.imem_addr), 32'h8);

        // MOV A,3; ADD A,14; JNC 0; OUT imm 5; HLT
        clear_rom();
        rom[0] = 8'h33; rom[1] = 8'h0E; rom[2] = 8'hE0; rom[3] = 8'hB5; rom[4] = 8'hC0;
        do_reset();
        check("t1_reset_addr", 32'(bus.imem_addr), 32'h0);
        check("t1_reset_req", 32'(bus.imem_req), 32'h1);
        check("t1_reset_led", 32'(led), 32'h0);
        repeat (3) step();
        check("t1_jnc_fall", 32'(bus.imem_addr), 32'h3);
        repeat (2) step();
        check("t1_led", 32'(led), 32'h005);
        check("t1_halted", 32'(halted), 32'h1);
        check("t1_req", 32'(bus.imem_req), 32'h0);
        repeat (2) step();
        check("t1_halt_pc", 32'(bus.imem_addr), 32'h4);
        // Reset while halted with led nonzero, valid held high on the same edge.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t1_rst_led", 32'(led), 32'h0);
        check("t1_rst_halted", 32'(halted), 32'h0);
        check("t1_rst_req", 32'(bus.imem_req), 32'h1);
        check("t1_rst_addr", 32'(bus.imem_addr), 32'h0);

        // IN/OUT channel indices, including out-of-range ones.
        clear_rom();
        sw = 8'hA7;
        rom[0] = 8'h61; rom[1] = 8'h92; rom[2] = 8'h93; rom[3] = 8'h25;
        rom[4] = 8'h40; rom[5] = 8'h91; rom[6] = 8'hC0;
        do_reset();
        repeat (7) step();
        check("io_led", 32'(led), 32'hA00);

        // Wait states before each of two ADD A,1.
        clear_rom();
        rom[0] = 8'h01; rom[1] = 8'h01; rom[2] = 8'h40; rom[3] = 8'h90; rom[4] = 8'hC0;
        do_reset();
        bus.imem_valid = 1'b0;
        repeat (3) step();
        check("ws_hold0", 32'(bus.imem_addr), 32'h0);
        bus.imem_valid = 1'b1;
        step();
        check("ws_pc1", 32'(bus.imem_addr), 32'h1);
        bus.imem_valid = 1'b0;
        repeat (3) step();
        check("ws_hold1", 32'(bus.imem_addr), 32'h1);
        bus.imem_valid = 1'b1;
        step();
        check("ws_pc2", 32'(bus.imem_addr), 32'h2);
        repeat (2) step();
        check("ws_a", 32'(led), 32'h002);

        // SUB borrow: MOV A,2; SUB A,3; JNC 7 falls through with a=0xF.
        clear_rom();
        rom[0] = 8'h32; rom[1] = 8'h83; rom[2] = 8'hE7; rom[3] = 8'h40; rom[4] = 8'h90;
        do_reset();
        repeat (3) step();
        check("sub_no_jump", 32'(bus.imem_addr), 32'h3);
        repeat (2) step();
        check("sub_a", 32'(led), 32'h00F);

        // JMP 15 then NOP wraps pc to 0.
        clear_rom();
        rom[0] = 8'hFF;
        do_reset();
        step();
        check("wrap_15", 32'(bus.imem_addr), 32'hF);
        step();
        check("wrap_0", 32'(bus.imem_addr), 32'h0);

        // Random programs, random wait states, occasional mid-run reset.
        for (int r = 0; r < 40; r++) begin
            reset = 1'b1;
            for (int i = 0; i < 16; i++) begin
                int op, imm;
                op  = $urandom_range(0, 15);
                imm = $urandom_range(0, 15);
                if (op == 12 && $urandom_range(0, 3) != 0) op = 9;
                if ((op == 2 || op == 6 || op == 9) && $urandom_range(0, 1) == 0) imm = $urandom_range(0, 3);
                rom[i] = 8'(op * 16 + imm);
            end
            sw = 8'($urandom);
            step();
            reset = 1'b0;
            repeat (60) begin
                bus.imem_valid = ($urandom_range(0, 9) < 7);
                sw = 8'($urandom);
                reset = ($urandom_range(0, 99) == 0);
                step();
            end
        end

        reset = 1'b0;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
